// File: rtl/matrix_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : matrix_row_scheduler
// Description : Emits L+1 progressively masked copies of a captured row,
//               L = min(slope, N-1), over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_row_scheduler #(
    parameter int N  = 10,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  in,
    input  logic [31:0]   slope,
    output logic          busy,
    output logic          row_valid,
    input  logic          row_ready,
    output logic [N-1:0]  row_data,
    output logic [IW-1:0] row_idx,
    output logic          row_last,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [N-1:0] C_ONES    = {N{1'b1}};
    localparam logic [31:0]  C_MAX_IDX = 32'(N - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [IW-1:0] last_q,  last_d;
    logic [N-1:0]  in_q,    in_d;
    logic [31:0]   slope_q, slope_d;
    logic          w_emit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            in_q    <= '0;
            slope_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            in_q    <= in_d;
            slope_q <= slope_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        in_d    = in_q;
        slope_d = slope_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    in_d    = in;
                    slope_d = slope;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Full 32-bit compare so large slopes with zero low bits still clamp.
                last_d  = (slope_q > C_MAX_IDX) ? C_MAX_IDX[IW-1:0] : slope_q[IW-1:0];
                idx_d   = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (row_ready) begin
                    if (idx_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_emit    = (state_q == S_EMIT);
        busy      = (state_q != S_IDLE);
        row_valid = w_emit;
        row_data  = w_emit ? (in_q & (C_ONES >> idx_q)) : '0;
        row_idx   = w_emit ? idx_q : '0;
        row_last  = w_emit && (idx_q == last_q);
        done      = (state_q == S_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_row_scheduler
// Description : Directed self-checking bench for matrix_row_scheduler (N=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_row_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  in;
    logic [31:0] slope;
    logic        busy;
    logic        row_valid;
    logic        row_ready;
    logic [9:0]  row_data;
    logic [3:0]  row_idx;
    logic        row_last;
    logic        done;

    int n_assert;
    int n_fail;

    logic [9:0] clamp_rows [10];

    matrix_row_scheduler #(.N(10), .IW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in        (in),
        .slope     (slope),
        .busy      (busy),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_last  (row_last),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_row(input string tag, input logic [9:0] d, input logic [3:0] i,
                           input logic l);
        chk({tag, ".valid"}, 32'(row_valid), 32'd1);
        chk({tag, ".data"},  32'(row_data),  32'(d));
        chk({tag, ".idx"},   32'(row_idx),   32'(i));
        chk({tag, ".last"},  32'(row_last),  32'(l));
        chk({tag, ".busy"},  32'(busy),      32'd1);
        chk({tag, ".done"},  32'(done),      32'd0);
    endtask

    task automatic chk_quiet(input string tag, input logic exp_busy, input logic exp_done);
        chk({tag, ".busy"},  32'(busy),      32'(exp_busy));
        chk({tag, ".valid"}, 32'(row_valid), 32'd0);
        chk({tag, ".data"},  32'(row_data),  32'd0);
        chk({tag, ".idx"},   32'(row_idx),   32'd0);
        chk({tag, ".last"},  32'(row_last),  32'd0);
        chk({tag, ".done"},  32'(done),      32'(exp_done));
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b1;
        in        = 10'h3FF;
        slope     = 32'd5;
        row_ready = 1'b1;
        clamp_rows = '{10'h2AA, 10'h0AA, 10'h0AA, 10'h02A, 10'h02A,
                       10'h00A, 10'h00A, 10'h002, 10'h002, 10'h000};

        // Reset overrides start and row_ready.
        tick();
        tick();
        chk_quiet("reset", 1'b0, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk_quiet("idle", 1'b0, 1'b0);

        // Basic job: four rows, done one cycle after the last handshake.
        in    = 10'h3FF;
        slope = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_quiet("basic.load", 1'b1, 1'b0);
        tick();
        chk_row("basic.r0", 10'h3FF, 4'd0, 1'b0); tick();
        chk_row("basic.r1", 10'h1FF, 4'd1, 1'b0); tick();
        chk_row("basic.r2", 10'h0FF, 4'd2, 1'b0); tick();
        chk_row("basic.r3", 10'h07F, 4'd3, 1'b1); tick();
        chk_quiet("basic.done", 1'b1, 1'b1);
        tick();
        chk_quiet("basic.idle", 1'b0, 1'b0);

        // Clamp: upper slope bits force L = 9.
        in    = 10'h2AA;
        slope = 32'h0001_0002;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            chk_row("clamp", clamp_rows[k], 4'(k), (k == 9));
            tick();
        end
        chk_quiet("clamp.done", 1'b1, 1'b1);
        tick();
        chk_quiet("clamp.idle", 1'b0, 1'b0);

        // Backpressure: idx 1 held for four visible cycles.
        in    = 10'h3FF;
        slope = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_row("bp.r0", 10'h3FF, 4'd0, 1'b0);
        tick();
        row_ready = 1'b0;
        chk_row("bp.hold0", 10'h1FF, 4'd1, 1'b0); tick();
        chk_row("bp.hold1", 10'h1FF, 4'd1, 1'b0); tick();
        chk_row("bp.hold2", 10'h1FF, 4'd1, 1'b0); tick();
        chk_row("bp.hold3", 10'h1FF, 4'd1, 1'b0);
        row_ready = 1'b1;
        tick();
        chk_row("bp.r2", 10'h0FF, 4'd2, 1'b1); tick();
        chk_quiet("bp.done", 1'b1, 1'b1);
        tick();
        chk_quiet("bp.idle", 1'b0, 1'b0);

        // slope = 0: single unmasked row.
        in    = 10'h155;
        slope = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_row("s0.r0", 10'h155, 4'd0, 1'b1); tick();
        chk_quiet("s0.done", 1'b1, 1'b1);
        tick();
        chk_quiet("s0.idle", 1'b0, 1'b0);

        // Start while busy is ignored, as is start during the DONE cycle.
        in    = 10'h3FF;
        slope = 32'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        row_ready = 1'b0;
        start     = 1'b1;
        in        = 10'h000;
        slope     = 32'd9;
        chk_row("busy.r0", 10'h3FF, 4'd0, 1'b0);
        tick();
        start     = 1'b0;
        row_ready = 1'b1;
        chk_row("busy.r0held", 10'h3FF, 4'd0, 1'b0); tick();
        chk_row("busy.r1", 10'h1FF, 4'd1, 1'b1); tick();
        chk_quiet("busy.done", 1'b1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_quiet("busy.startindone", 1'b0, 1'b0);
        tick();
        chk_quiet("busy.idle", 1'b0, 1'b0);

        // Mid-job reset at idx 2, then a new job straight after.
        in    = 10'h3FF;
        slope = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_row("mrst.r0", 10'h3FF, 4'd0, 1'b0); tick();
        chk_row("mrst.r1", 10'h1FF, 4'd1, 1'b0); tick();
        chk_row("mrst.r2", 10'h0FF, 4'd2, 1'b0);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        chk_quiet("mrst.abort", 1'b0, 1'b0);
        rst   = 1'b0;
        in    = 10'h3C3;
        slope = 32'd2;
        tick();
        start = 1'b0;
        chk_quiet("mrst.newload", 1'b1, 1'b0);
        tick();
        chk_row("mrst.n0", 10'h3C3, 4'd0, 1'b0); tick();
        chk_row("mrst.n1", 10'h1C3, 4'd1, 1'b0); tick();
        chk_row("mrst.n2", 10'h0C3, 4'd2, 1'b1); tick();
        chk_quiet("mrst.done", 1'b1, 1'b1);
        tick();
        chk_quiet("mrst.idle", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_row_scheduler.md
MATRIX_ROW_SCHEDULER -- requirements
Module: matrix_row_scheduler

Interface
REQ-001 Parameter N, default 10: bits per row and maximum rows per job.
REQ-002 Parameter IW, default 4: width of the row index; the SHALL hold 2^IW >= N.
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port start  input  1: job request; sampled only in IDLE.
REQ-006 Port in  input  N: operand row, captured with start.
REQ-007 Port slope  input  32: unsigned shift limit, captured with start.
REQ-008 Port busy  output  1: high in every state except IDLE.
REQ-009 Port row_valid  output  1: row_data, row_idx and row_last are valid.
REQ-010 Port row_ready  input  1: downstream accepts the row.
REQ-011 Port row_data  output  N: masked row.
REQ-012 Port row_idx  output  IW: index of the current row.
REQ-013 Port row_last  output  1: current row is the final row of the job.
REQ-014 Port done  output  1: single-cycle job-completion pulse.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, LOAD, EMIT and DONE.
REQ-016 IDLE with start=1 SHALL capture in into in_q and slope into slope_q, then go to LOAD.
REQ-017 LOAD SHALL compute L = min(slope_q, N-1) over the full 32 bits, set idx=0, then go to EMIT.
- Upper slope bits are not ignored.
REQ-018 In EMIT, row_valid SHALL be 1.
- row_data = in_q & ({N{1'b1}} >> idx).
- row_idx = idx.
- row_last = (idx == L).
REQ-019 Latency: start accepted at edge t -> first row_valid visible in the cycle after edge t+1, i.e. 2 cycles.
REQ-020 A handshake SHALL occur when row_valid and row_ready are both high at a clock edge.
- Non-last row: idx increments and the state stays EMIT.
- Last row: the state goes to DONE.
REQ-021 Under row_ready=0, row_valid, row_data, row_idx and row_last SHALL hold stable, and idx SHALL not advance.
REQ-022 Each job SHALL emit exactly L+1 rows, with idx running 0..L in order and no gaps or repeats.
REQ-023 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
- busy stays 1 in DONE.
REQ-024 start outside IDLE SHALL be ignored, with no effect on in_q, slope_q or the current job.
REQ-025 start in the same cycle DONE returns to IDLE SHALL be ignored.
- The earliest new start is sampled in the cycle after done.
REQ-026 slope=0 SHALL give a single row equal to in, with row_last=1 on that row.
REQ-027 in and slope changes after capture SHALL not affect the running job.
REQ-028 row_valid, row_last and done SHALL be 0 in IDLE and LOAD.
- row_data and row_idx SHALL be 0 whenever row_valid=0.

Reset
REQ-029 While rst=1 at a clock edge, the following SHALL apply.
- state=IDLE.
- idx=0.
- in_q=0.
- slope_q=0.
- busy=0, row_valid=0, row_last=0, done=0.
- row_data=0, row_idx=0.
REQ-030 rst SHALL override start and row_ready in the same cycle.
REQ-031 rst asserted mid-job SHALL abort the job with no done pulse, and no further rows SHALL be emitted.
REQ-032 After rst deasserts, the block SHALL accept start on the next edge.

Verification (N=10)
REQ-033 Bench scenario, basic job with row_ready tied 1:
- Stimulus: in=10'h3FF, slope=3, start pulse.
- Response: rows 3FF, 1FF, 0FF, 07F with idx 0..3.
- row_last only on idx 3.
- done pulse one cycle after the last handshake.
REQ-034 Bench scenario, clamp:
- Stimulus: slope=32'h0001_0002, in=10'h2AA.
- Response: 10 rows, the last being row_data=10'h000 at idx 9.
REQ-035 Bench scenario, backpressure:
- Stimulus: slope=2, in=10'h3FF, row_ready low for 3 cycles during idx 1.
- Response: 1FF held stable for 4 cycles.
- Exactly 3 rows total.
REQ-036 Bench scenario, slope=0:
- Stimulus: in=10'h155.
- Response: a single row 155 with row_last=1, then done.
REQ-037 Bench scenario, start while busy:
- Stimulus: second start with slope=9 during EMIT.
- Response: ignored; the original row count is unchanged.
REQ-038 Bench scenario, mid-job reset:
- Stimulus: rst pulse during idx 2.
- Response: next cycle row_valid=0 and busy=0, with no done pulse.
- A following job runs correctly from idx 0.
